// File: rtl/muxdatos_sync.sv
// muxdatos_sync -- synchronous multiplexer for time/date/timer snapshots.
//
// Follows one of NCANAL source channels. Each channel provides NPAL words of
// ANCHO bits plus an am/pm flag. A channel marks its data as consistent with
// a one-cycle listo_in strobe. On that strobe the active channel's data is
// captured into registered outputs. Switching to another channel is
// deferred until the target channel strobes listo_in. That way the output
// never mixes a half-updated source with a stale one.
//
// Optional feature (macro MUXDATOS_TIMEOUT_EN):
//   When the macro is defined, a switch that has waited TIMEOUT cycles is
//   forced. The block loads the target's current data and pulses both
//   valido_out and error. When the macro is not defined, the wait counter
//   is not built and the block waits indefinitely.
//
// Ports:
//   clk         in   rising-edge clock
//   reset       in   asynchronous, active-high reset
//   datos_in    in   channel c word w at [(c*NPAL+w)*ANCHO +: ANCHO]
//   ap_in       in   am/pm flag per channel
//   listo_in    in   per-channel "data consistent" strobe
//   sel         in   requested channel, used only with cambio_req
//   cambio_req  in   one-cycle switch request
//   datos_out   out  registered snapshot of the active channel
//   ampm_out    out  registered am/pm flag of the snapshot
//   valido_out  out  one-cycle pulse when the snapshot was updated
//   canal_act   out  currently active channel
//   ocupado     out  high while a switch is pending
//   error       out  one-cycle pulse on a rejected request or a timeout
//
// state  | meaning
// SEGUIR | track the active channel and capture it on its listo_in
// ESPERA | switch pending; outputs frozen until the target's listo_in
module muxdatos_sync #(
  parameter int NCANAL  = 2,
  parameter int NPAL    = 3,
  parameter int ANCHO   = 24,
  parameter int TIMEOUT = 255
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NCANAL*NPAL*ANCHO-1:0]   datos_in,
  input  logic [NCANAL-1:0]              ap_in,
  input  logic [NCANAL-1:0]              listo_in,
  input  logic [$clog2(NCANAL)-1:0]      sel,
  input  logic                           cambio_req,
  output logic [NPAL*ANCHO-1:0]          datos_out,
  output logic                           ampm_out,
  output logic                           valido_out,
  output logic [$clog2(NCANAL)-1:0]      canal_act,
  output logic                           ocupado,
  output logic                           error
);

  localparam int SELW = $clog2(NCANAL);
  localparam int NPOT = 2 ** SELW;
  localparam int WW   = NPAL * ANCHO;
  localparam logic [SELW:0] NCH = (SELW + 1)'(NCANAL);

  if (NCANAL < 2 || NCANAL > 8 || TIMEOUT < 1 || TIMEOUT > 65535) begin : g_param_fuera_de_rango
    $error("muxdatos_sync: NCANAL must be 2..8 and TIMEOUT 1..65535");
  end

  typedef enum logic {SEGUIR, ESPERA} estado_t;

  estado_t         est, est_nxt;
  logic [SELW-1:0] tgt, tgt_nxt, canal_nxt;
  logic [WW-1:0]   dat_nxt;
  logic            ap_nxt, val_nxt, err_nxt;
  logic            req_ok, req_bad, tmo;

  // Channel views padded to a power of two so that any sel/tgt index is in
  // range. Indexes that are not real channels read as idle and zero.
  logic [WW-1:0]   dat_arr [NPOT];
  logic [NPOT-1:0] ap_v, lst_v;

  for (genvar i = 0; i < NPOT; i++) begin : g_canal
    if (i < NCANAL) begin : g_real
      assign dat_arr[i] = datos_in[i*WW +: WW];
      assign ap_v[i]    = ap_in[i];
      assign lst_v[i]   = listo_in[i];
    end else begin : g_pad
      assign dat_arr[i] = '0;
      assign ap_v[i]    = 1'b0;
      assign lst_v[i]   = 1'b0;
    end
  end

  assign req_ok  = cambio_req && ({1'b0, sel} < NCH);
  assign req_bad = cambio_req && !({1'b0, sel} < NCH);
  assign ocupado = (est == ESPERA);

`ifdef MUXDATOS_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);

  logic [CW-1:0] cnt, cnt_nxt, cnt_inc;

  // The switch is forced on the edge where the counter would reach TIMEOUT.
  // So exactly TIMEOUT cycles are spent in ESPERA.
  assign cnt_inc = (cnt == TMAX) ? cnt : cnt + 1'b1;
  assign tmo     = (est == ESPERA) && (cnt_inc == TMAX);

  always_comb begin
    cnt_nxt = cnt;
    if (est == SEGUIR) begin
      if (req_ok && sel != canal_act) cnt_nxt = '0;
    end else begin
      cnt_nxt = cnt_inc;
      if (req_ok) cnt_nxt = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt <= '0;
    else       cnt <= cnt_nxt;
  end
`else
  assign tmo = 1'b0;
`endif

  always_comb begin
    est_nxt   = est;
    tgt_nxt   = tgt;
    canal_nxt = canal_act;
    dat_nxt   = datos_out;
    ap_nxt    = ampm_out;
    val_nxt   = 1'b0;
    err_nxt   = req_bad;
    case (est)
      SEGUIR: begin
        if (req_ok && sel != canal_act) begin
          est_nxt = ESPERA;
          tgt_nxt = sel;
        end else if (lst_v[canal_act]) begin
          dat_nxt = dat_arr[canal_act];
          ap_nxt  = ap_v[canal_act];
          val_nxt = 1'b1;
        end
      end
      ESPERA: begin
        // A new valid request wins over the target's strobe and over a timeout.
        if (req_ok) begin
          if (sel == canal_act) est_nxt = SEGUIR;
          else                  tgt_nxt = sel;
        end else if (lst_v[tgt] || tmo) begin
          dat_nxt   = dat_arr[tgt];
          ap_nxt    = ap_v[tgt];
          canal_nxt = tgt;
          val_nxt   = 1'b1;
          est_nxt   = SEGUIR;
          if (tmo) err_nxt = 1'b1;
        end
      end
      default: est_nxt = SEGUIR;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      est        <= SEGUIR;
      tgt        <= '0;
      canal_act  <= '0;
      datos_out  <= '0;
      ampm_out   <= 1'b0;
      valido_out <= 1'b0;
      error      <= 1'b0;
    end else begin
      est        <= est_nxt;
      tgt        <= tgt_nxt;
      canal_act  <= canal_nxt;
      datos_out  <= dat_nxt;
      ampm_out   <= ap_nxt;
      valido_out <= val_nxt;
      error      <= err_nxt;
    end
  end

endmodule
